// File: rtl/regfile_writeback_pkg.sv
// achieve_pkg: shared widths and types for the writeback stage.
package achieve_pkg;
   localparam int XLEN = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS = 32;
   typedef logic [XLEN-1:0] xdata_t;
   typedef logic [REG_ADDR_W-1:0] raddr_t;
   typedef logic [NUM_REGS-1:0] rmask_t;
   typedef enum logic {PRIO_LSU = 1'b0, PRIO_ALU = 1'b1} prio_e;
   function automatic rmask_t reg_bit(input raddr_t r, input logic en);
      return en ? rmask_t'(1) << r : '0;
   endfunction
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: result channels, issue, register-file write and bypass signals.
interface regfile_writeback_if import achieve_pkg::*;;
   logic alu_valid, alu_ready, lsu_valid, lsu_ready, issue_valid;
   logic wb_we, fwd1_valid, fwd2_valid;
   raddr_t alu_rd, lsu_rd, issue_rd, wb_rd, rs1, rs2;
   xdata_t alu_data, lsu_data, wb_data, fwd1_data, fwd2_data;
   rmask_t busy_mask;
   modport master(
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             issue_valid, issue_rd, rs1, rs2,
      input  alu_ready, lsu_ready, busy_mask, wb_rd, wb_data, wb_we,
             fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
   );
   modport slave(
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             issue_valid, issue_rd, rs1, rs2,
      output alu_ready, lsu_ready, busy_mask, wb_rd, wb_data, wb_we,
             fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
   );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// wb_arbiter: two-source round-robin grant; the priority bit flips only under contention.
module wb_arbiter import achieve_pkg::*; (
   input  logic clk,
   input  logic rst_n,
   input  logic alu_valid,
   input  logic lsu_valid,
   output logic alu_grant,
   output logic lsu_grant
);
   prio_e prio;
   always_comb begin
      lsu_grant = rst_n && lsu_valid && (!alu_valid || prio == PRIO_LSU);
      alu_grant = rst_n && alu_valid && (!lsu_valid || prio == PRIO_ALU);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) prio <= PRIO_LSU;
      else if (alu_valid && lsu_valid) prio <= prio == PRIO_LSU ? PRIO_ALU : PRIO_LSU;
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU/LSU results onto the register-file write port,
// tracks pending writes and bypasses the just-written value to the read ports.
module regfile_writeback import achieve_pkg::*; (
   input logic clk,
   input logic rst_n,
   regfile_writeback_if.slave bus
);
   logic alu_grant, lsu_grant, grant;
   raddr_t g_rd;
   xdata_t g_data;
   wb_arbiter u_arb (
      .clk(clk),
      .rst_n(rst_n),
      .alu_valid(bus.alu_valid),
      .lsu_valid(bus.lsu_valid),
      .alu_grant(alu_grant),
      .lsu_grant(lsu_grant)
   );
   assign bus.alu_ready = alu_grant;
   assign bus.lsu_ready = lsu_grant;
   always_comb begin
      grant = alu_grant || lsu_grant;
      g_rd = alu_grant ? bus.alu_rd : bus.lsu_rd;
      g_data = alu_grant ? bus.alu_data : bus.lsu_data;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.wb_we <= 1'b0;
         bus.wb_rd <= '0;
         bus.wb_data <= '0;
         bus.busy_mask <= '0;
         bus.fwd1_valid <= 1'b0;
         bus.fwd1_data <= '0;
         bus.fwd2_valid <= 1'b0;
         bus.fwd2_data <= '0;
      end else begin
         bus.wb_we <= grant && g_rd != '0;
         if (grant) begin
            bus.wb_rd <= g_rd;
            bus.wb_data <= g_data;
         end
         // set applied after clear so a same-edge issue keeps the bit busy
         bus.busy_mask <= ((bus.busy_mask & ~reg_bit(g_rd, grant)) | reg_bit(bus.issue_rd, bus.issue_valid)) & ~rmask_t'(1);
         bus.fwd1_valid <= bus.wb_we && bus.wb_rd == bus.rs1 && bus.rs1 != '0;
         bus.fwd1_data <= bus.wb_data;
         bus.fwd2_valid <= bus.wb_we && bus.wb_rd == bus.rs2 && bus.rs2 != '0;
         bus.fwd2_data <= bus.wb_data;
      end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: random + directed stimulus; a reference model predicts each cycle's
// outputs into a queue that an independent monitor drains after every clock edge.
module tb_regfile_writeback;
   import achieve_pkg::*;
   typedef struct {
      logic we; logic [4:0] rd; logic [63:0] data; logic [31:0] busy;
      logic f1v; logic [63:0] f1d; logic f2v; logic [63:0] f2d;
   } exp_t;
   logic clk = 0;
   logic rst_n = 0;
   always #5 clk = ~clk;
   regfile_writeback_if bus();
   regfile_writeback dut(.clk(clk), .rst_n(rst_n), .bus(bus));
   exp_t q[$];
   int passed = 0;
   int total = 0;
   bit a_v, l_v;
   bit [4:0] a_rd, l_rd;
   bit [63:0] a_d, l_d;
   bit [31:0] m_busy;
   bit m_we;
   bit [4:0] m_rd;
   bit [63:0] m_data;
   bit lsu_turn;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, act, exp);
   endtask

   task automatic cycle(input bit iv, input bit [4:0] ir, input bit [4:0] r1, input bit [4:0] r2);
      exp_t e;
      bit ag, lg;
      bit [4:0] rd;
      @(negedge clk);
      bus.alu_valid = a_v; bus.alu_rd = a_rd; bus.alu_data = a_d;
      bus.lsu_valid = l_v; bus.lsu_rd = l_rd; bus.lsu_data = l_d;
      bus.issue_valid = iv; bus.issue_rd = ir; bus.rs1 = r1; bus.rs2 = r2;
      #1;
      lg = l_v && (!a_v || lsu_turn);
      ag = a_v && (!l_v || !lsu_turn);
      if (a_v && l_v) lsu_turn = !lsu_turn;
      chk("alu_ready", bus.alu_ready, ag);
      chk("lsu_ready", bus.lsu_ready, lg);
      e.f1v = m_we && m_rd == r1 && r1 != 0; e.f1d = m_data;
      e.f2v = m_we && m_rd == r2 && r2 != 0; e.f2d = m_data;
      m_we = 0;
      if (ag || lg) begin
         rd = ag ? a_rd : l_rd;
         m_rd = rd;
         m_data = ag ? a_d : l_d;
         m_we = rd != 0;
         m_busy[rd] = 0;
      end
      if (iv && ir != 0) m_busy[ir] = 1;
      m_busy[0] = 0;
      e.we = m_we; e.rd = m_rd; e.data = m_data; e.busy = m_busy;
      q.push_back(e);
      if (ag) a_v = 0;
      if (lg) l_v = 0;
   endtask

   task automatic do_reset();
      exp_t e;
      @(negedge clk);
      rst_n = 0;
      bus.alu_valid = 1; bus.lsu_valid = 1;
      #1;
      chk("rst_wb_we", bus.wb_we, 0);
      chk("rst_wb_rd", bus.wb_rd, 0);
      chk("rst_wb_data", bus.wb_data, 0);
      chk("rst_busy", bus.busy_mask, 0);
      chk("rst_f1v", bus.fwd1_valid, 0);
      chk("rst_f1d", bus.fwd1_data, 0);
      chk("rst_f2v", bus.fwd2_valid, 0);
      chk("rst_f2d", bus.fwd2_data, 0);
      chk("rst_alu_ready", bus.alu_ready, 0);
      chk("rst_lsu_ready", bus.lsu_ready, 0);
      bus.alu_valid = 0; bus.lsu_valid = 0; bus.issue_valid = 0;
      a_v = 0; l_v = 0;
      m_busy = 0; m_we = 0; m_rd = 0; m_data = 0; lsu_turn = 1;
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
      e = '{0, 0, 0, 0, 0, 0, 0, 0};
      q.push_back(e);
   endtask

   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("wb_we", bus.wb_we, e.we);
         chk("wb_rd", bus.wb_rd, e.rd);
         chk("wb_data", bus.wb_data, e.data);
         chk("busy_mask", bus.busy_mask, e.busy);
         chk("fwd1_valid", bus.fwd1_valid, e.f1v);
         chk("fwd2_valid", bus.fwd2_valid, e.f2v);
         if (e.f1v) chk("fwd1_data", bus.fwd1_data, e.f1d);
         if (e.f2v) chk("fwd2_data", bus.fwd2_data, e.f2d);
      end
   end

   initial begin
      bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
      bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
      bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
      do_reset();
      cycle(1, 5, 0, 0);
      a_v = 1; a_rd = 5; a_d = 64'h1234;
      cycle(0, 0, 5, 0);
      a_v = 1; a_rd = 8; a_d = 64'h88; l_v = 1; l_rd = 7; l_d = 64'h77;
      repeat (3) cycle(0, 0, 7, 8);
      a_v = 1; a_rd = 0; a_d = 64'hFFFF;
      cycle(0, 0, 0, 0);
      cycle(1, 9, 0, 0);
      a_v = 1; a_rd = 9; a_d = 64'h99;
      cycle(1, 9, 0, 0);
      a_v = 1; a_rd = 3; a_d = 64'hABCD;
      cycle(0, 0, 3, 4);
      cycle(0, 0, 3, 4);
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 699) do_reset();
         if (!a_v && $urandom_range(0, 2) != 0) begin
            a_v = 1; a_rd = 5'($urandom_range(0, 15)); a_d = {$urandom, $urandom};
         end
         if (!l_v && $urandom_range(0, 2) != 0) begin
            l_v = 1; l_rd = 5'($urandom_range(0, 15)); l_d = {$urandom, $urandom};
         end
         cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
               5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      end
      do_reset();
      cycle(1, 4, 0, 0);
      a_v = 1; a_rd = 2; a_d = 64'h2222;
      cycle(1, 8, 0, 0);
      do_reset();
      a_v = 1; a_rd = 12; a_d = 64'hC; l_v = 1; l_rd = 13; l_d = 64'hD;
      repeat (3) cycle(0, 0, 12, 13);
      repeat (2) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
